// File: rtl/axil_sram_responder.sv
// AXI4-Lite-style responder in front of a word-organised SRAM.
// Independent read and write paths, each with a fixed response latency.
module axil_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned WRITE_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [31:0] wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic        bresp,
  output logic        bvalid
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  RLAT  = 4'(READ_LAT);
  localparam logic [3:0]  WLAT  = 4'(WRITE_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ({1'b0, a - ADDR_BASE} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // Read path state and next-state signals
  r_state_t    r_state, r_state_d;
  logic [3:0]  r_cnt, r_cnt_d;
  logic [31:0] r_addr, r_addr_d;
  logic [31:0] rdata_d;
  logic        rresp_d, rvalid_d, arready_d;
  logic        r_sample;
  logic [31:0] r_samp_addr;
  logic [31:0] rd_word;
  logic [4:0]  r_sh;

  // Write path state and next-state signals
  w_state_t    w_state, w_state_d;
  logic [3:0]  w_cnt, w_cnt_d;
  logic [31:0] w_addr, w_addr_d;
  logic [31:0] w_data, w_data_d;
  logic [31:0] w_strb, w_strb_d;
  logic        bresp_d, bvalid_d, awready_d, wready_d;
  logic        commit;
  logic [31:0] cm_data, cm_strb;
  logic [31:0] wr_old, wr_mask;
  logic [4:0]  w_sh;
  logic        mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0] mem_wdata;

  // Read FSM: next state, counter and response capture
  always_comb begin
    r_state_d   = r_state;
    r_cnt_d     = r_cnt;
    r_addr_d    = r_addr;
    rdata_d     = rdata;
    rresp_d     = rresp;
    rvalid_d    = rvalid;
    r_sample    = 1'b0;
    r_samp_addr = r_addr;
    rd_word     = 32'h0;
    r_sh        = 5'h0;
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_addr_d = araddr;
          r_cnt_d  = RLAT;
          if (READ_LAT == 0) begin
            r_state_d   = R_RESP;
            r_sample    = 1'b1;
            r_samp_addr = araddr;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt <= 4'd1) begin
          r_state_d = R_RESP;
          r_sample  = 1'b1;
        end else begin
          r_cnt_d = r_cnt - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Memory is sampled only on entry to R_RESP, so a same-edge commit is not visible
    if (r_sample) begin
      rd_word  = mem[word_idx(r_samp_addr)];
      r_sh     = {r_samp_addr[1:0], 3'b000};
      rvalid_d = 1'b1;
      if (in_range(r_samp_addr)) begin
        rdata_d = rd_word >> r_sh;
        rresp_d = 1'b0;
      end else begin
        rdata_d = 32'h0;
        rresp_d = 1'b1;
      end
    end
    arready_d = (r_state_d == R_IDLE);
  end

  // Write FSM: next state, counter and commit
  always_comb begin
    w_state_d = w_state;
    w_cnt_d   = w_cnt;
    w_addr_d  = w_addr;
    w_data_d  = w_data;
    w_strb_d  = w_strb;
    bresp_d   = bresp;
    bvalid_d  = bvalid;
    commit    = 1'b0;
    cm_data   = w_data;
    cm_strb   = w_strb;
    case (w_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_addr_d  = awaddr;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          w_cnt_d  = WLAT;
          if (WRITE_LAT == 0) begin
            w_state_d = W_RESP;
            commit    = 1'b1;
            cm_data   = wdata;
            cm_strb   = wstrb;
          end else begin
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt <= 4'd1) begin
          w_state_d = W_RESP;
          commit    = 1'b1;
        end else begin
          w_cnt_d = w_cnt - 4'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = !in_range(w_addr);
    end
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
  end

  // Read-modify-write merge; bits shifted past bit 31 fall off
  always_comb begin
    mem_widx  = word_idx(w_addr);
    w_sh      = {w_addr[1:0], 3'b000};
    wr_old    = mem[mem_widx];
    wr_mask   = cm_strb << w_sh;
    mem_wdata = (wr_old & ~wr_mask) | ((cm_data & cm_strb) << w_sh);
    mem_we    = commit && in_range(w_addr) && rst;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // State and output registers; reset aborts both paths without a response
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'h0;
      r_addr  <= 32'h0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      rresp   <= 1'b0;
      w_state <= W_IDLE;
      w_cnt   <= 4'h0;
      w_addr  <= 32'h0;
      w_data  <= 32'h0;
      w_strb  <= 32'h0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 1'b0;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_addr  <= r_addr_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
      w_state <= w_state_d;
      w_cnt   <= w_cnt_d;
      w_addr  <= w_addr_d;
      w_data  <= w_data_d;
      w_strb  <= w_strb_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Directed bench for axil_sram_responder: three instances with different
// latencies share the stimulus; sel routes handshakes and observed outputs.
module tb_axil_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready, rresp, rvalid, awready, wready, bresp, bvalid;
  logic [31:0] rdata;
  int          sel;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        arready_v [3];
  logic        rresp_v   [3];
  logic        rvalid_v  [3];
  logic        awready_v [3];
  logic        wready_v  [3];
  logic        bresp_v   [3];
  logic        bvalid_v  [3];
  logic [31:0] rdata_v   [3];

  always #5 clk = ~clk;

  // Instance 0: READ_LAT=1/WRITE_LAT=1, 1: 0/0, 2: 1/5
  for (genvar g = 0; g < 3; g++) begin : g_dut
    axil_sram_responder #(
      .ADDR_BASE  (32'h8000_0000),
      .DEPTH_WORDS(1024),
      .READ_LAT   ((g == 1) ? 0 : 1),
      .WRITE_LAT  ((g == 0) ? 1 : ((g == 1) ? 0 : 5))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .araddr (araddr),
      .arvalid(arvalid && (sel == g)),
      .arready(arready_v[g]),
      .rready (rready && (sel == g)),
      .rdata  (rdata_v[g]),
      .rresp  (rresp_v[g]),
      .rvalid (rvalid_v[g]),
      .awaddr (awaddr),
      .awvalid(awvalid && (sel == g)),
      .awready(awready_v[g]),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .wvalid (wvalid && (sel == g)),
      .wready (wready_v[g]),
      .bready (bready && (sel == g)),
      .bresp  (bresp_v[g]),
      .bvalid (bvalid_v[g])
    );
  end

  assign arready = arready_v[sel];
  assign rresp   = rresp_v[sel];
  assign rvalid  = rvalid_v[sel];
  assign awready = awready_v[sel];
  assign wready  = wready_v[sel];
  assign bresp   = bresp_v[sel];
  assign bvalid  = bvalid_v[sel];
  assign rdata   = rdata_v[sel];

  function automatic int rlat_of(input int s);
    return (s == 1) ? 0 : 1;
  endfunction

  function automatic int wlat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 0 : 5);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready"}, 32'(arready), 32'h0);
    chk({tag, "_awready"}, 32'(awready), 32'h0);
    chk({tag, "_wready"},  32'(wready),  32'h0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'h0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'h0);
    chk({tag, "_rdata"},   rdata,        32'h0);
    chk({tag, "_rresp"},   32'(rresp),   32'h0);
    chk({tag, "_bresp"},   32'(bresp),   32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic er,
                    input int hold, input string tag);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin tick; n++; end
    chk({tag, "_arready"}, 32'(arready), 32'h1);
    tick;
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick; n++; end
    chk({tag, "_rlat"},   32'(n),      32'(rlat_of(sel)));
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h1);
    chk({tag, "_rdata"},  rdata,       ed);
    chk({tag, "_rresp"},  32'(rresp),  32'(er));
    repeat (hold) begin
      tick;
      chk({tag, "_hold_rvalid"},  32'(rvalid),  32'h1);
      chk({tag, "_hold_rdata"},   rdata,        ed);
      chk({tag, "_hold_rresp"},   32'(rresp),   32'(er));
      chk({tag, "_hold_arready"}, 32'(arready), 32'h0);
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk({tag, "_rvalid_clr"},  32'(rvalid),  32'h0);
    chk({tag, "_arready_ret"}, 32'(arready), 32'h1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s,
                    input logic er, input int hold, input string tag);
    int n;
    awaddr  = a;
    awvalid = 1'b1;
    wdata   = d;
    wstrb   = s;
    wvalid  = 1'b1;
    chk({tag, "_wready_early"}, 32'(wready), 32'h0);
    n = 0;
    while (awready !== 1'b1 && n < 20) begin tick; n++; end
    chk({tag, "_awready"}, 32'(awready), 32'h1);
    tick;
    awvalid = 1'b0;
    n = 0;
    while (wready !== 1'b1 && n < 20) begin tick; n++; end
    chk({tag, "_wready"}, 32'(wready), 32'h1);
    tick;
    wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick; n++; end
    chk({tag, "_blat"},   32'(n),      32'(wlat_of(sel)));
    chk({tag, "_bvalid"}, 32'(bvalid), 32'h1);
    chk({tag, "_bresp"},  32'(bresp),  32'(er));
    repeat (hold) begin
      tick;
      chk({tag, "_hold_bvalid"},  32'(bvalid),  32'h1);
      chk({tag, "_hold_bresp"},   32'(bresp),   32'(er));
      chk({tag, "_hold_awready"}, 32'(awready), 32'h0);
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk({tag, "_bvalid_clr"},  32'(bvalid),  32'h0);
    chk({tag, "_awready_ret"}, 32'(awready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel     = 0;
    rst     = 1'b0;
    araddr  = 32'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = 32'h0;
    awvalid = 1'b0;
    wdata   = 32'h0;
    wstrb   = 32'h0;
    wvalid  = 1'b0;
    bready  = 1'b0;

    // Reset state and release
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b1;
    tick;
    chk("rel_arready", 32'(arready), 32'h1);
    chk("rel_awready", 32'(awready), 32'h1);

    // Word write then read, latency 1/1
    wr(32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 0, "w_word");
    rd(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 0, "r_word");

    // Byte write and sub-word reads
    wr(32'h8000_0001, 32'h0000_00AA, 32'h0000_00FF, 1'b0, 0, "w_byte");
    rd(32'h8000_0000, 32'hDEAD_AAEF, 1'b0, 0, "r_off0");
    rd(32'h8000_0001, 32'h00DE_ADAA, 1'b0, 0, "r_off1");
    rd(32'h8000_0002, 32'h0000_DEAD, 1'b0, 0, "r_off2");

    // Out-of-range on both sides of the window
    rd(32'h7FFF_FFFC, 32'h0, 1'b1, 0, "r_oor_lo");
    wr(32'h8000_1000, 32'h0000_1234, 32'h0000_FFFF, 1'b1, 0, "w_oor_hi");
    rd(32'h8000_0000, 32'hDEAD_AAEF, 1'b0, 0, "r_after_oor");
    rd(32'h8000_1000, 32'h0, 1'b1, 0, "r_oor_hi");

    // Last word of the window and a half-word merge into it
    wr(32'h8000_0FFC, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, 0, "w_top");
    wr(32'h8000_0FFE, 32'h0000_1234, 32'h0000_FFFF, 1'b0, 0, "w_half");
    rd(32'h8000_0FFC, 32'h1234_F00D, 1'b0, 0, "r_top");
    rd(32'h8000_0FFE, 32'h0000_1234, 1'b0, 0, "r_half");

    // Backpressure on both response channels
    rd(32'h8000_0000, 32'hDEAD_AAEF, 1'b0, 5, "r_bp");
    wr(32'h8000_0008, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0, 5, "w_bp");
    rd(32'h8000_0008, 32'h0BAD_F00D, 1'b0, 0, "r_bp_chk");

    // Same-cycle read sample and write commit, latency 0/0
    sel = 1;
    wr(32'h8000_0004, 32'h1111_1111, 32'hFFFF_FFFF, 1'b0, 0, "sc_init");
    awaddr  = 32'h8000_0004;
    awvalid = 1'b1;
    chk("sc_awready", 32'(awready), 32'h1);
    tick;
    awvalid = 1'b0;
    chk("sc_wready",  32'(wready),  32'h1);
    chk("sc_arready", 32'(arready), 32'h1);
    wdata   = 32'h5555_5555;
    wstrb   = 32'hFFFF_FFFF;
    wvalid  = 1'b1;
    araddr  = 32'h8000_0004;
    arvalid = 1'b1;
    tick;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    chk("sc_rvalid", 32'(rvalid), 32'h1);
    chk("sc_rdata",  rdata,       32'h1111_1111);
    chk("sc_bvalid", 32'(bvalid), 32'h1);
    chk("sc_bresp",  32'(bresp),  32'h0);
    rready = 1'b1;
    bready = 1'b1;
    tick;
    rready = 1'b0;
    bready = 1'b0;
    chk("sc_rvalid_clr", 32'(rvalid), 32'h0);
    chk("sc_bvalid_clr", 32'(bvalid), 32'h0);
    rd(32'h8000_0004, 32'h5555_5555, 1'b0, 0, "sc_after");

    // Reset while the write waits out its latency, write latency 5
    sel = 2;
    wr(32'h8000_0010, 32'h600D_CAFE, 32'hFFFF_FFFF, 1'b0, 0, "rw_init");
    awaddr  = 32'h8000_0010;
    awvalid = 1'b1;
    wdata   = 32'hBAD0_BAD0;
    wstrb   = 32'hFFFF_FFFF;
    wvalid  = 1'b1;
    chk("rw_awready", 32'(awready), 32'h1);
    tick;
    awvalid = 1'b0;
    chk("rw_wready", 32'(wready), 32'h1);
    tick;
    wvalid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk_zero("rw_rst1");
    tick;
    chk_zero("rw_rst2");
    rst = 1'b1;
    tick;
    chk("rw_rel_arready", 32'(arready), 32'h1);
    chk("rw_rel_awready", 32'(awready), 32'h1);
    chk("rw_rel_wready",  32'(wready),  32'h0);
    repeat (6) tick;
    chk("rw_no_bvalid", 32'(bvalid), 32'h0);
    rd(32'h8000_0010, 32'h600D_CAFE, 1'b0, 0, "rw_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_sram_responder.md
Name: axil_sram_responder

Overview:
- AXI4-Lite-style responder (subordinate) that fronts a word-organised on-chip memory. It is the memory-side end of the load/store unit's bus.
- Accepts one read and one write transaction at a time, on independent read and write paths, each with programmable response latency.
- Handles byte/half/word access through address-offset shifting and a per-bit write mask. Out-of-range addresses return an error response.

Parameters:
- ADDR_BASE, 32'h8000_0000: byte address of word 0.
- DEPTH_WORDS, 1024: memory depth in 32-bit words; must be a power of two.
- READ_LAT, 1: extra wait cycles between address accept and rvalid; range 0..15.
- WRITE_LAT, 1: extra wait cycles between data accept and bvalid; range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets)
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rready  in  1  read data ready
- rdata  out  32  read data, right-aligned to the address offset
- rresp  out  1  0=OKAY, 1=error
- rvalid  out  1  read data valid
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data, right-aligned
- wstrb  in  32  per-bit write enable, right-aligned (0xFF byte, 0xFFFF half, 0xFFFFFFFF word)
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bready  in  1  write response ready
- bresp  out  1  0=OKAY, 1=error
- bvalid  out  1  write response valid

Behaviour:
- Reset:
  - While rst=0, all outputs are 0 and both FSMs go to IDLE.
  - arready and awready are 1 in the first cycle after rst returns to 1.
  - Memory contents are not cleared.
- Address decoding:
  - In range when ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS.
  - Word index = (addr - ADDR_BASE) >> 2. Offset sh = 8*addr[1:0].
- Read FSM: states R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On arvalid, latch araddr and load the counter with READ_LAT. Go to R_WAIT, or straight to R_RESP when READ_LAT=0.
  - R_WAIT: arready=0. Decrement the counter each cycle; go to R_RESP when it reaches 1.
  - Entry into R_RESP: register rdata = mem[idx] >> sh (zero-filled) and rresp=0, and set rvalid=1.
  - Out-of-range read: rdata=0, rresp=1.
  - Timing: handshake accepted in cycle T gives rvalid=1 in cycle T+1+READ_LAT.
  - R_RESP: rvalid, rdata and rresp are held stable until rready=1. After the rvalid&rready cycle: rvalid=0 and arready=1 in the next cycle.
- Write FSM: states W_IDLE, W_DATA, W_WAIT, W_RESP.
  - W_IDLE: awready=1. On awvalid, latch awaddr and go to W_DATA.
  - W_DATA: awready=0, wready=1. On wvalid, latch wdata and wstrb, and load the counter with WRITE_LAT. Go to W_WAIT, or to W_RESP when WRITE_LAT=0.
  - W_WAIT: decrement the counter; go to W_RESP when it reaches 1.
  - Entry into W_RESP (commit point): mem[idx] = (mem[idx] & ~(wstrb<<sh)) | ((wdata & wstrb)<<sh). Shifted bits beyond bit 31 are dropped; accesses never cross a word. Set bvalid=1, bresp=0.
  - Out-of-range write: no memory update, bresp=1.
  - W_RESP: bvalid and bresp are held until bready=1. The cycle after the handshake: bvalid=0, W_IDLE.
  - wvalid arriving before the address is accepted is ignored; wready stays 0 until W_DATA.
- Concurrency:
  - The read and write paths run independently, so both may be active in the same cycle.
  - If a read samples (R_RESP entry) in the same cycle that a write commits to the same word, the read returns the pre-write data.
  - A read sampling in any later cycle sees the new data.
- Reset mid-operation:
  - Aborts any in-flight transaction with no response.
  - A write not yet committed is lost; a committed write persists.
- The counter is 4 bits wide and never underflows.

Test Plan:
- Word write then read: READ_LAT=WRITE_LAT=1. Write 0x8000_0000 with 0xDEADBEEF, wstrb 0xFFFFFFFF. Read 0x8000_0000. Required: bresp=0; rdata=0xDEADBEEF, rresp=0; rvalid in cycle T+2 after the ar handshake.
- Byte write / sub-word read: from 0xDEADBEEF, write 0x8000_0001 with 0x000000AA, wstrb 0xFF.
  - Read 0x8000_0000 -> 0xDEADAAEF.
  - Read 0x8000_0001 -> 0x00DEADAA.
  - Read 0x8000_0002 -> 0x0000DEAD.
- Out of range:
  - Read 0x7FFF_FFFC -> rresp=1, rdata=0.
  - Write 0x8000_1000 (DEPTH_WORDS=1024) with 0x1234 -> bresp=1, and a read of 0x8000_0000 is unchanged.
- Backpressure: hold rready=0 for 5 cycles after rvalid.
  - Required: rvalid, rdata and rresp stay stable, and arready=0 throughout.
  - Same for bready=0 with bvalid and bresp.
- Same-cycle read/write: with READ_LAT=0 and WRITE_LAT=0, time a read so it samples 0x8000_0004 in the cycle that a write of 0x55555555 commits there (old value 0x11111111). Required: the read returns 0x11111111 and the next read returns 0x55555555.
- Reset in W_WAIT: WRITE_LAT=5; drive rst=0 two cycles after the w handshake.
  - Required: all outputs are 0 during reset, and arready=awready=1 in the first cycle after release.
  - Required: a subsequent read of that address returns the old value.
